hazard_fwd_unit: RTL and testbench

- Hazard and forwarding controller for the 5-stage 32-bit MIPS pipeline.
- Generates the 2-bit forwarding selectors that drive the execute-stage operand multiplexers, where 00 selects the register file, 01 the writeback result and 10 ALUOutM.
- Also generates the decode-stage branch-compare forwards, the F/D stall signals and the E flush.
- Tracks destination registers of in-flight instructions in an internal E/M/W shadow pipeline, and tracks a multi-cycle multiply/divide unit (MDU) busy window with a down-counter.

---
 rtl/hazard_fwd_unit.sv | 131 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline.
// Ports: decode fields in; E/D forward selects, F/D stall, E flush, MDU busy out.
module hazard_fwd_unit #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] dest_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              branch_d,
  input  logic              mdu_start_d,
  input  logic              hilo_read_d,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              mdu_busy
);

  typedef logic [REG_AW-1:0] reg_t;

  localparam logic [7:0] LAT = 8'(MDU_LAT);

  reg_t       rs_e;
  reg_t       rt_e;
  reg_t       dest_e;
  logic       rw_e;
  logic       ld_e;
  reg_t       dest_m;
  logic       rw_m;
  logic       ld_m;
  reg_t       dest_w;
  logic       rw_w;
  logic [7:0] cnt;

  logic lwstall;
  logic brstall;
  logic mdustall;
  logic stall;

  // A stage supplies register r only if it writes a non-$0 match.
  function automatic logic hit(
    input logic en,
    input reg_t d,
    input reg_t r
  );
    return en && (d != '0) && (d == r);
  endfunction

  always_comb begin
    forward_a_e = 2'b00;
    if (hit(rw_m, dest_m, rs_e))
      forward_a_e = 2'b10;
    else if (hit(rw_w, dest_w, rs_e))
      forward_a_e = 2'b01;

    forward_b_e = 2'b00;
    if (hit(rw_m, dest_m, rt_e))
      forward_b_e = 2'b10;
    else if (hit(rw_w, dest_w, rt_e))
      forward_b_e = 2'b01;

    forward_a_d = hit(rw_m, dest_m, rs_d);
    forward_b_d = hit(rw_m, dest_m, rt_d);

    lwstall = hit(ld_e, dest_e, rs_d)
            | hit(ld_e, dest_e, rt_d);

    // Decode-stage compare cannot see E results, nor M load data.
    brstall = branch_d
            & (hit(rw_e, dest_e, rs_d)
             | hit(rw_e, dest_e, rt_d)
             | hit(ld_m, dest_m, rs_d)
             | hit(ld_m, dest_m, rt_d));

    mdu_busy = (cnt != 8'd0);
    mdustall = mdu_busy & (hilo_read_d | mdu_start_d);

    stall   = lwstall | brstall | mdustall;
    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_e   <= '0;
      rt_e   <= '0;
      dest_e <= '0;
      rw_e   <= 1'b0;
      ld_e   <= 1'b0;
      dest_m <= '0;
      rw_m   <= 1'b0;
      ld_m   <= 1'b0;
      dest_w <= '0;
      rw_w   <= 1'b0;
      cnt    <= 8'd0;
    end else begin
      dest_w <= dest_m;
      rw_w   <= rw_m;
      dest_m <= dest_e;
      rw_m   <= rw_e;
      ld_m   <= ld_e;
      if (stall) begin
        rs_e   <= '0;
        rt_e   <= '0;
        dest_e <= '0;
        rw_e   <= 1'b0;
        ld_e   <= 1'b0;
      end else begin
        rs_e   <= rs_d;
        rt_e   <= rt_d;
        dest_e <= dest_d;
        rw_e   <= regwrite_d;
        ld_e   <= memtoreg_d;
      end
      if (mdu_start_d && !stall)
        cnt <= LAT;
      else if (cnt != 8'd0)
        cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomised + directed bench for hazard_fwd_unit.
// Instruction-level model of the E/M/W occupants checked every cycle.
module tb_hazard_fwd_unit;

  localparam int AW  = 5;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_d;
  logic [AW-1:0] rt_d;
  logic [AW-1:0] dest_d;
  logic          regwrite_d;
  logic          memtoreg_d;
  logic          branch_d;
  logic          mdu_start_d;
  logic          hilo_read_d;
  logic [1:0]    forward_a_e;
  logic [1:0]    forward_b_e;
  logic          forward_a_d;
  logic          forward_b_d;
  logic          stall_f;
  logic          stall_d;
  logic          flush_e;
  logic          mdu_busy;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_AW(AW), .MDU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .dest_d(dest_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
    .branch_d(branch_d), .mdu_start_d(mdu_start_d),
    .hilo_read_d(hilo_read_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .mdu_busy(mdu_busy)
  );

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dest;
    logic          rw;
    logic          ld;
  } ins_t;

  // In-flight instructions and remaining MDU cycles.
  ins_t ex_i, mem_i, wb_i;
  int   mdu_left;

  ins_t cur;
  bit   cur_br, cur_st, cur_hr, cur_rst, cur_stall;

  int nvec = 0;
  int nbad = 0;

  localparam ins_t NOP = '0;

  function automatic ins_t mk(int s, int t, int d, bit w, bit l);
    ins_t i;
    i.rs = AW'(s); i.rt = AW'(t); i.dest = AW'(d);
    i.rw = w; i.ld = l;
    return i;
  endfunction

  // Does instruction i produce register r (via result or load data)?
  function automatic bit produces(ins_t i, bit kind, logic [AW-1:0] r);
    return kind && i.dest != 0 && i.dest == r;
  endfunction

  function automatic logic [1:0] src_sel(logic [AW-1:0] r);
    if (produces(mem_i, mem_i.rw, r)) return 2'b10;
    if (produces(wb_i, wb_i.rw, r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit needs_stall();
    bit lu, br, md;
    lu = produces(ex_i, ex_i.ld, cur.rs) || produces(ex_i, ex_i.ld, cur.rt);
    br = cur_br && (produces(ex_i, ex_i.rw, cur.rs)
                 || produces(ex_i, ex_i.rw, cur.rt)
                 || produces(mem_i, mem_i.ld, cur.rs)
                 || produces(mem_i, mem_i.ld, cur.rt));
    md = (mdu_left > 0) && (cur_hr || cur_st);
    return lu || br || md;
  endfunction

  task automatic drive(ins_t d, bit br, bit st, bit hr, bit r);
    logic [10:0] exp_v, act_v;
    cur = d; cur_br = br; cur_st = st; cur_hr = hr; cur_rst = r;
    rs_d = d.rs; rt_d = d.rt; dest_d = d.dest;
    regwrite_d = d.rw; memtoreg_d = d.ld;
    branch_d = br; mdu_start_d = st; hilo_read_d = hr; rst = r;
    #1;
    cur_stall = needs_stall();
    exp_v = {src_sel(ex_i.rs), src_sel(ex_i.rt),
             produces(mem_i, mem_i.rw, cur.rs),
             produces(mem_i, mem_i.rw, cur.rt),
             cur_stall, cur_stall, cur_stall, mdu_left > 0};
    act_v = {forward_a_e, forward_b_e, forward_a_d, forward_b_d,
             stall_f, stall_d, flush_e, mdu_busy};
    nvec++;
    if (act_v !== exp_v) begin
      nbad++;
      $display("FAIL model t=%0t got fae,fbe,fad,fbd,sf,sd,fe,busy=%b expected %b",
               $time, act_v, exp_v);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (cur_rst) begin
      ex_i = '0; mem_i = '0; wb_i = '0; mdu_left = 0;
    end else begin
      wb_i  = mem_i;
      mem_i = ex_i;
      ex_i  = cur_stall ? NOP : cur;
      if (cur_st && !cur_stall) mdu_left = LAT;
      else if (mdu_left > 0) mdu_left--;
    end
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) begin
      drive(NOP, 0, 0, 0, 0);
      adv();
    end
  endtask

  task automatic op(ins_t d);
    drive(d, 0, 0, 0, 0);
    adv();
  endtask

  initial begin
    ins_t add3, lw5, use5, add7, lw7, beq7, z, add9, div, mfhi;
    add3 = mk(1, 2, 3, 1, 0);
    lw5  = mk(1, 0, 5, 1, 1);
    use5 = mk(0, 5, 6, 1, 0);
    add7 = mk(1, 2, 7, 1, 0);
    lw7  = mk(1, 0, 7, 1, 1);
    beq7 = mk(7, 0, 0, 0, 0);
    z    = mk(0, 0, 0, 1, 1);
    add9 = mk(9, 9, 9, 1, 0);
    div  = mk(1, 2, 0, 0, 0);
    mfhi = mk(0, 0, 8, 1, 0);

    rst = 1'b1;
    rs_d = '0; rt_d = '0; dest_d = '0;
    regwrite_d = 0; memtoreg_d = 0; branch_d = 0;
    mdu_start_d = 0; hilo_read_d = 0;
    cur = NOP; cur_rst = 1;
    @(posedge clk);
    ex_i = '0; mem_i = '0; wb_i = '0; mdu_left = 0;
    @(negedge clk);

    drive(NOP, 0, 0, 0, 0);
    chk("reset_outputs",
        8'({forward_a_e, forward_b_e, forward_a_d, forward_b_d,
            stall_f, stall_d, flush_e, mdu_busy}), 8'h00);
    adv();

    // back-to-back dependence -> M forward
    op(add3);
    op(mk(3, 4, 6, 1, 0));
    drive(NOP, 0, 0, 0, 0);
    chk("fwd_a_e_mem", 8'(forward_a_e), 8'h2);
    adv();
    nops(3);

    // one instruction apart -> W forward
    op(add3);
    op(NOP);
    op(mk(3, 4, 6, 1, 0));
    drive(NOP, 0, 0, 0, 0);
    chk("fwd_a_e_wb", 8'(forward_a_e), 8'h1);
    adv();
    nops(3);

    // both M and W write $3 -> M wins
    op(add3);
    op(mk(0, 0, 3, 1, 0));
    op(mk(3, 4, 6, 1, 0));
    drive(NOP, 0, 0, 0, 0);
    chk("fwd_a_e_prio", 8'(forward_a_e), 8'h2);
    adv();
    nops(3);

    // load-use
    op(lw5);
    drive(use5, 0, 0, 0, 0);
    chk("lw_stall", 8'({stall_f, stall_d, flush_e}), 8'h7);
    adv();
    drive(use5, 0, 0, 0, 0);
    chk("lw_release", 8'({stall_f, stall_d, flush_e}), 8'h0);
    adv();
    drive(NOP, 0, 0, 0, 0);
    chk("lw_fwd_b_e", 8'(forward_b_e), 8'h1);
    adv();
    nops(3);

    // branch after ALU writer
    op(add7);
    drive(beq7, 1, 0, 0, 0);
    chk("br_alu_stall", 8'(stall_f), 8'h1);
    adv();
    drive(beq7, 1, 0, 0, 0);
    chk("br_alu_go", 8'({stall_f, forward_a_d}), 8'h1);
    adv();
    nops(3);

    // branch after load: two stalls
    op(lw7);
    drive(beq7, 1, 0, 0, 0);
    chk("br_ld_stall1", 8'(stall_d), 8'h1);
    adv();
    drive(beq7, 1, 0, 0, 0);
    chk("br_ld_stall2", 8'(stall_d), 8'h1);
    adv();
    drive(beq7, 1, 0, 0, 0);
    chk("br_ld_go", 8'({stall_d, forward_a_d}), 8'h0);
    adv();
    nops(3);

    // $0 never a hazard
    op(z); op(z); op(z);
    drive(mk(0, 0, 0, 0, 0), 1, 0, 0, 0);
    chk("zero_filter",
        8'({forward_a_e, forward_b_e, forward_a_d, forward_b_d, stall_f}),
        8'h00);
    adv();
    nops(3);

    // MDU busy window
    drive(div, 0, 1, 0, 0);
    chk("div_accept", 8'({stall_f, mdu_busy}), 8'h0);
    adv();
    drive(mfhi, 0, 0, 1, 0);
    chk("mfhi_t1", 8'({stall_f, mdu_busy}), 8'h3);
    adv();
    drive(div, 0, 1, 0, 0);
    chk("div2_t2", 8'({stall_f, mdu_busy}), 8'h3);
    adv();
    for (int k = 3; k <= 4; k++) begin
      drive(mfhi, 0, 0, 1, 0);
      chk("mfhi_busy", 8'({stall_f, mdu_busy}), 8'h3);
      adv();
    end
    drive(mfhi, 0, 0, 1, 0);
    chk("mfhi_t5", 8'({stall_f, mdu_busy}), 8'h0);
    adv();
    nops(3);

    // reset mid-run with live shadow state and MDU busy
    op(mk(1, 2, 0, 0, 0));
    cur_st = 0;
    drive(div, 0, 1, 0, 0);
    adv();
    op(add9); op(add9); op(add9);
    drive(add9, 0, 0, 0, 1);
    chk("pre_rst", 8'({forward_a_e, mdu_busy}), 8'h5);
    adv();
    drive(NOP, 0, 0, 0, 0);
    chk("post_rst",
        8'({forward_a_e, forward_b_e, forward_a_d, forward_b_d,
            stall_f, stall_d, flush_e, mdu_busy}), 8'h00);
    adv();

    // random traffic over a small register window
    for (int n = 0; n < 3000; n++) begin
      ins_t d;
      bit l, w;
      l = ($urandom_range(0, 3) == 0);
      w = l || ($urandom_range(0, 1) == 1);
      d = mk($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), w, l);
      drive(d, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0);
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
